// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command and state encodings shared by the SPI RAM and its users.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {
        IDLE,
        TX_HOLD_ST
    } ram_state_e;

endpackage

// File: rtl/spi_sp_ram.sv
// spi_sp_ram: single-port RAM driven by SPI slave command words; reads are
// returned on dout with tx_valid held long enough for the slave to shift them out.
module spi_sp_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       err
);

    localparam int CW = $clog2(TX_HOLD + 1);

    logic [7:0]           mem [MEM_DEPTH];
    logic                 rx_q;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic                 wr_vld_q, wr_vld_d, rd_vld_q, rd_vld_d;
    logic [7:0]           dout_q, dout_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    ram_state_e           state_q, state_d;
    logic                 acc, mem_we, rd_ok;
    cmd_e                 cmd;

    // A command only counts on the rising edge of the slave's level-valid.
    assign acc = rx_valid && !rx_q;
    assign cmd = cmd_e'(din[9:8]);

    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_vld_d  = wr_vld_q;
        rd_addr_d = rd_addr_q;
        rd_vld_d  = rd_vld_q;
        dout_d    = dout_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        rd_ok     = 1'b0;
        if (acc) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr_d = din[ADDR_SIZE-1:0];
                    wr_vld_d  = 1'b1;
                end
                CMD_WR_DATA: begin
                    mem_we = wr_vld_q;
                    err_d  = !wr_vld_q;
                end
                CMD_RD_ADDR: begin
                    rd_addr_d = din[ADDR_SIZE-1:0];
                    rd_vld_d  = 1'b1;
                end
                CMD_RD_DATA: begin
                    rd_ok = rd_vld_q;
                    err_d = !rd_vld_q;
                    if (rd_vld_q) dout_d = mem[rd_addr_q];
                end
            endcase
        end
    end

    // Any accepted command ends a hold; a good read restarts it from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rd_ok) begin
            state_d = TX_HOLD_ST;
            cnt_d   = '0;
        end else if (acc || (state_q == TX_HOLD_ST && cnt_q == CW'(TX_HOLD - 1))) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == TX_HOLD_ST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            dout_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
        end else begin
            rx_q      <= rx_valid;
            wr_addr_q <= wr_addr_d;
            wr_vld_q  <= wr_vld_d;
            rd_addr_q <= rd_addr_d;
            rd_vld_q  <= rd_vld_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
        end
    end

    // Array is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr_q] <= din[7:0];
    end

    assign dout     = dout_q;
    assign err      = err_q;
    assign tx_valid = (state_q == TX_HOLD_ST);

endmodule

// File: tb/tb_spi_sp_ram.sv
// tb_spi_sp_ram: directed and random command streams against a behavioural
// RAM model; expected outputs are queued per clock and checked by a monitor.
module tb_spi_sp_ram;

    localparam int TX_HOLD = 9;

    typedef struct {
        logic       tx;
        logic [7:0] dout;
        logic       err;
    } exp_t;

    logic       clk, rst_n, rx_valid, tx_valid, err;
    logic [9:0] din;
    logic [7:0] dout;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] m_mem [256];
    logic [7:0] m_wa, m_ra, m_dout;
    logic       m_wv, m_rv, m_prev;
    int         m_h;

    spi_sp_ram dut (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout), .tx_valid(tx_valid), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if ({tx_valid, dout, err} !== {e.tx, e.dout, e.err}) begin
                n_bad++;
                $display("FAIL out @%0t: tx/dout/err got %b/%h/%b want %b/%h/%b",
                         $time, tx_valid, dout, err, e.tx, e.dout, e.err);
            end
        end
    end

    task automatic step(input logic v, input logic [9:0] d);
        logic acc, er;
        exp_t e;
        rx_valid = v;
        din      = d;
        acc      = v && !m_prev;
        m_prev   = v;
        er       = 1'b0;
        if (acc) begin
            case (d[9:8])
                2'd0: begin m_wa = d[7:0]; m_wv = 1'b1; end
                2'd1: if (m_wv) m_mem[m_wa] = d[7:0]; else er = 1'b1;
                2'd2: begin m_ra = d[7:0]; m_rv = 1'b1; end
                2'd3: if (m_rv) m_dout = m_mem[m_ra]; else er = 1'b1;
            endcase
            m_h = (d[9:8] == 2'd3 && m_rv) ? TX_HOLD : 0;
        end else if (m_h > 0) begin
            m_h--;
        end
        e = '{m_h > 0, m_dout, er};
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] p, input int hi, input int lo);
        repeat (hi) step(1'b1, {c, p});
        repeat (lo) step(1'b0, {c, p});
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        n_cmp++;
        if ({tx_valid, dout, err} !== 10'b0) begin
            n_bad++;
            $display("FAIL async_reset: tx/dout/err got %b/%h/%b want 0/00/0", tx_valid, dout, err);
        end
        m_prev = 1'b0; m_wv = 1'b0; m_rv = 1'b0; m_wa = '0; m_ra = '0;
        m_dout = '0; m_h = 0;
        e = '{1'b0, 8'h00, 1'b0};
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = '0;
        do_reset();
        for (int a = 0; a < 256; a++) begin
            send(2'd0, 8'(a), 1, 1);
            send(2'd1, 8'($urandom_range(0, 255)), 1, 1);
        end
        // basic write then read-back with a full hold
        send(2'd0, 8'h3C, 1, 1);
        send(2'd1, 8'hA5, 1, 1);
        send(2'd2, 8'h3C, 1, 1);
        send(2'd3, 8'h00, 1, 12);
        // long level and changing din while high must write only once
        send(2'd0, 8'h10, 1, 1);
        repeat (10) step(1'b1, 10'b01_0000_0001);
        repeat (10) step(1'b1, 10'b01_0101_0101);
        send(2'd2, 8'h10, 0, 1);
        send(2'd2, 8'h10, 1, 1);
        send(2'd3, 8'h00, 1, 11);
        // no address after reset -> errors, no write, no hold
        do_reset();
        send(2'd1, 8'h11, 1, 2);
        send(2'd3, 8'h00, 1, 2);
        send(2'd2, 8'h00, 1, 1);
        send(2'd3, 8'h00, 1, 11);
        send(2'd0, 8'h05, 1, 1);
        send(2'd1, 8'h77, 1, 1);
        send(2'd0, 8'h06, 1, 1);
        send(2'd1, 8'h88, 1, 1);
        // abort at hold clk 4
        send(2'd2, 8'h05, 1, 1);
        send(2'd3, 8'h00, 1, 3);
        send(2'd2, 8'h06, 1, 10);
        // back-to-back reads restart the hold without a gap
        send(2'd2, 8'h05, 1, 1);
        send(2'd3, 8'h00, 1, 2);
        send(2'd3, 8'h00, 1, 3);
        send(2'd2, 8'h06, 1, 1);
        send(2'd3, 8'h00, 1, 12);
        // reset mid-hold, memory retained
        send(2'd2, 8'h05, 1, 1);
        send(2'd3, 8'h00, 1, 3);
        do_reset();
        send(2'd3, 8'h00, 1, 2);
        send(2'd2, 8'h05, 1, 1);
        send(2'd3, 8'h00, 1, 12);
        for (int i = 0; i < 1500; i++)
            send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                 $urandom_range(1, 3), $urandom_range(0, 4));
        send(2'd0, 8'h00, 0, 12);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
